// File: rtl/fifo_rd_stream_adapter_if.sv
// Stream adapter bus: FIFO read port plus valid/ready output stream.
// master = adapter side, slave = FIFO/downstream side.
interface fifo_rd_stream_adapter_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  fifo_rrdy_i;
   logic                  fifo_reb_o;
   logic [DATA_WIDTH-1:0] fifo_dout_i;
   logic                  m_valid_o;
   logic                  m_ready_i;
   logic [DATA_WIDTH-1:0] m_data_o;
   logic [1:0]            count_o;

   modport master (
      input  fifo_rrdy_i,
      input  fifo_dout_i,
      input  m_ready_i,
      output fifo_reb_o,
      output m_valid_o,
      output m_data_o,
      output count_o
   );

   modport slave (
      output fifo_rrdy_i,
      output fifo_dout_i,
      output m_ready_i,
      input  fifo_reb_o,
      input  m_valid_o,
      input  m_data_o,
      input  count_o
   );
endinterface

// File: rtl/fifo_rd_stream_adapter.sv
// FIFO read port to valid/ready stream, registered output + skid entry.
// Ports: clk_i, rst_i (sync, active-high), bus (master modport).
module fifo_rd_stream_adapter #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   fifo_rd_stream_adapter_if.master bus
);
   logic                  r_out_v;
   logic [DATA_WIDTH-1:0] r_out_d;
   logic                  r_skid_v;
   logic [DATA_WIDTH-1:0] r_skid_d;
   logic                  r_infl;

   logic       w_pop;
   logic [1:0] w_cnt;
   logic       w_reb;

   assign w_pop = r_out_v & bus.m_ready_i;

   // in-flight word is reserved space, so it counts here
   assign w_cnt = {1'b0, r_out_v}
                + {1'b0, r_skid_v}
                + {1'b0, r_infl};

   assign w_reb = bus.fifo_rrdy_i & ~rst_i
                & ((w_cnt < 2'd2) | w_pop);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_out_v  <= 1'b0;
         r_out_d  <= '0;
         r_skid_v <= 1'b0;
         r_skid_d <= '0;
         r_infl   <= 1'b0;
      end else begin
         r_infl <= w_reb;
         if (!r_out_v) begin
            if (r_infl) begin
               r_out_v <= 1'b1;
               r_out_d <= bus.fifo_dout_i;
            end
         end else if (w_pop) begin
            if (r_skid_v) begin
               r_out_d <= r_skid_d;
               if (r_infl) r_skid_d <= bus.fifo_dout_i;
               else        r_skid_v <= 1'b0;
            end else if (r_infl) begin
               r_out_d <= bus.fifo_dout_i;
            end else begin
               r_out_v <= 1'b0;
            end
         end else if (r_infl) begin
            // cnt <= 2 guarantees the skid is free here
            r_skid_v <= 1'b1;
            r_skid_d <= bus.fifo_dout_i;
         end
      end
   end

   assign bus.fifo_reb_o = w_reb;
   assign bus.m_valid_o  = r_out_v;
   assign bus.m_data_o   = r_out_d;
   assign bus.count_o    = {1'b0, r_out_v} + {1'b0, r_skid_v};
endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Directed bench for fifo_rd_stream_adapter with a FIFO read-port model.
// Immediate assertions at each check point; summary line at the end.
module tb_fifo_rd_stream_adapter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ready = 1'b0;
   logic en = 1'b0;
   logic force_rrdy = 1'b0;

   logic [7:0] mem [0:255];
   int wr_ptr = 0;
   int rd_ptr = 0;
   logic [7:0] dout = 8'h00;

   logic [7:0] got [0:255];
   int n_got = 0;

   int n_vec = 0;
   int n_err = 0;
   int base;

   always #5 clk = ~clk;

   fifo_rd_stream_adapter_if #(.DATA_WIDTH(8)) u_if ();

   assign u_if.fifo_rrdy_i = force_rrdy | (en && (wr_ptr != rd_ptr));
   assign u_if.fifo_dout_i = dout;
   assign u_if.m_ready_i   = ready;

   fifo_rd_stream_adapter #(.DATA_WIDTH(8)) u_dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (u_if)
   );

   // FIFO read-port model: registered output, reset empties it
   always @(posedge clk) begin
      if (rst) begin
         rd_ptr <= wr_ptr;
         dout   <= 8'h00;
      end else if (u_if.fifo_reb_o) begin
         dout   <= mem[rd_ptr[7:0]];
         rd_ptr <= rd_ptr + 1;
      end
   end

   // log of accepted stream words
   always @(posedge clk) begin
      if (!rst && u_if.m_valid_o && u_if.m_ready_i) begin
         got[n_got[7:0]] <= u_if.m_data_o;
         n_got <= n_got + 1;
      end
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      mem[wr_ptr[7:0]] = d;
      wr_ptr++;
   endtask

   initial begin
      // reset held 3 cycles with rrdy forced high
      force_rrdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         #1;
         chk("rst_reb", u_if.fifo_reb_o, 0);
         chk("rst_valid", u_if.m_valid_o, 0);
         chk("rst_count", u_if.count_o, 0);
         chk("rst_data", u_if.m_data_o, 0);
      end
      cyc();
      rst = 1'b0;
      force_rrdy = 1'b0;
      en = 1'b1;
      ready = 1'b1;
      #1;
      chk("idle_reb", u_if.fifo_reb_o, 0);

      // cold start
      cyc();
      push(8'h11);
      #1;
      chk("cold_reb1", u_if.fifo_reb_o, 1);
      chk("cold_v1", u_if.m_valid_o, 0);
      cyc();
      #1;
      chk("cold_reb2", u_if.fifo_reb_o, 0);
      chk("cold_v2", u_if.m_valid_o, 0);
      cyc();
      #1;
      chk("cold_v3", u_if.m_valid_o, 1);
      chk("cold_d3", u_if.m_data_o, 8'h11);
      chk("cold_c3", u_if.count_o, 1);
      cyc();
      #1;
      chk("cold_v4", u_if.m_valid_o, 0);
      chk("cold_c4", u_if.count_o, 0);

      // streaming 16 words
      cyc();
      for (int i = 0; i < 16; i++) push(8'(i));
      #1;
      chk("strm_reb", u_if.fifo_reb_o, 1);
      cyc();
      for (int i = 0; i < 16; i++) begin
         cyc();
         #1;
         chk("strm_v", u_if.m_valid_o, 1);
         chk("strm_d", u_if.m_data_o, i);
      end
      cyc();
      #1;
      chk("strm_end", u_if.m_valid_o, 0);

      // backpressure
      cyc();
      for (int i = 0; i < 8; i++) push(8'hA0 + 8'(i));
      base = rd_ptr;
      #1;
      chk("bp_reb0", u_if.fifo_reb_o, 1);
      cyc();
      cyc();
      ready = 1'b0;
      #1;
      chk("bp_v", u_if.m_valid_o, 1);
      chk("bp_d", u_if.m_data_o, 8'hA0);
      chk("bp_reb", u_if.fifo_reb_o, 0);
      for (int k = 0; k < 4; k++) begin
         cyc();
         #1;
         chk("bp_hold_d", u_if.m_data_o, 8'hA0);
         chk("bp_hold_c", u_if.count_o, 2);
         chk("bp_hold_reb", u_if.fifo_reb_o, 0);
      end
      chk("bp_reads", rd_ptr - base, 2);
      cyc();
      ready = 1'b1;
      #1;
      chk("bp_r0", u_if.m_data_o, 8'hA0);
      chk("bp_r0_reb", u_if.fifo_reb_o, 1);
      cyc();
      #1;
      chk("bp_r1", u_if.m_data_o, 8'hA1);
      chk("bp_r1_v", u_if.m_valid_o, 1);
      cyc();
      #1;
      chk("bp_r2", u_if.m_data_o, 8'hA2);
      chk("bp_r2_v", u_if.m_valid_o, 1);
      for (int k = 0; k < 10; k++) cyc();

      // empty gaps with random ready
      base = n_got;
      for (int i = 0; i < 10; i++) push(8'hC0 + 8'(i));
      for (int i = 0; i < 40; i++) begin
         cyc();
         en = (i % 2) == 0;
         ready = 1'($urandom_range(0, 1));
         #1;
         chk("gap_reb", u_if.fifo_reb_o & ~u_if.fifo_rrdy_i, 0);
      end
      cyc();
      en = 1'b1;
      ready = 1'b1;
      for (int k = 0; k < 14; k++) cyc();
      chk("gap_n", n_got - base, 10);
      for (int i = 0; i < 10; i++)
         chk("gap_d", got[8'(base + i)], 8'hC0 + 8'(i));

      // reset mid-operation
      cyc();
      ready = 1'b0;
      for (int i = 0; i < 4; i++) push(8'hD0 + 8'(i));
      #1;
      chk("mr_reb", u_if.fifo_reb_o, 1);
      cyc();
      cyc();
      cyc();
      #1;
      chk("mr_c2", u_if.count_o, 2);
      rst = 1'b1;
      ready = 1'b1;
      #1;
      chk("mr_reb_rst", u_if.fifo_reb_o, 0);
      cyc();
      rst = 1'b0;
      #1;
      chk("mr_v", u_if.m_valid_o, 0);
      chk("mr_c", u_if.count_o, 0);
      base = n_got;
      push(8'hE5);
      push(8'hE6);
      for (int k = 0; k < 6; k++) cyc();
      chk("mr_n", n_got - base, 2);
      chk("mr_d0", got[8'(base)], 8'hE5);
      chk("mr_d1", got[8'(base + 1)], 8'hE6);

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end
endmodule
